// File: rtl/iq_stream_arbiter.sv
// iq_stream_arbiter: round-robin burst arbiter feeding N_CH IQ streams into one registered output
module iq_stream_arbiter #(
  parameter int N_CH = 4,
  parameter int DW = 16,
  parameter int BURST = 8,
  localparam int CHW = $clog2(N_CH)
) (
  input  logic                 iclk,
  input  logic                 irst_n,
  input  logic [N_CH-1:0]      i_ch_en,
  input  logic [N_CH-1:0]      i_valid,
  output logic [N_CH-1:0]      o_ready,
  input  logic [N_CH*DW-1:0]   i_i,
  input  logic [N_CH*DW-1:0]   i_q,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [DW-1:0]        o_i,
  output logic [DW-1:0]        o_q,
  output logic [CHW-1:0]       o_ch,
  output logic                 o_busy
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_n;
  logic [CHW-1:0] gnt, gnt_n, last, last_n, pick, idx;
  logic [7:0] cnt, cnt_n;
  logic [N_CH-1:0] req;
  logic found, xfer, g_en, g_vld;
  assign req = i_valid & i_ch_en;
  assign g_en = i_ch_en[gnt];
  assign g_vld = i_valid[gnt];
  assign o_busy = state == GRANT;
  assign o_ready = (o_busy && g_en && (!o_valid || i_ready)) ? {{(N_CH-1){1'b0}}, 1'b1} << gnt : '0;
  assign xfer = |(o_ready & i_valid);
  always_comb begin
    pick = '0;
    idx = '0;
    found = 1'b0;
    for (int j = 1; j <= N_CH; j++) begin
      idx = CHW'((int'(last) + j) % N_CH);
      if (!found && req[idx]) begin
        pick = idx;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_n = state;
    gnt_n = gnt;
    last_n = last;
    cnt_n = cnt;
    if (state == IDLE) begin
      if (found) begin
        state_n = GRANT;
        gnt_n = pick;
        cnt_n = '0;
      end
    end else if (xfer) begin
      cnt_n = cnt + 8'd1;
      if (cnt == 8'(BURST - 1)) begin
        state_n = IDLE;
        last_n = gnt;
      end
    end else if (!g_vld || !g_en) begin
      state_n = IDLE;
      last_n = gnt;
    end
  end
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state <= IDLE;
      gnt <= '0;
      last <= CHW'(N_CH - 1);
      cnt <= '0;
    end else begin
      state <= state_n;
      gnt <= gnt_n;
      last <= last_n;
      cnt <= cnt_n;
    end
  end
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      o_valid <= 1'b0;
      o_i <= '0;
      o_q <= '0;
      o_ch <= '0;
    end else if (xfer) begin
      o_valid <= 1'b1;
      o_i <= i_i[gnt*DW +: DW];
      o_q <= i_q[gnt*DW +: DW];
      o_ch <= gnt;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end
endmodule
